// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART IO block: IO address decode bits, STATUS
// register bit positions, and the TX/RX state encodings.
// ---------------------------------------------------------------------------
package uart_pkg;

    // mem_addr bit that selects the DATA register / the STATUS register
    localparam int ADDR_DATA_BIT   = 12;
    localparam int ADDR_STATUS_BIT = 13;

    // STATUS register bit positions
    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_OVERRUN      = 2;
    localparam int ST_IRQ_EN       = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_if.sv
// ---------------------------------------------------------------------------
// uart_if
// CPU IO bus of the UART block, bundled for the CPU side (master) and the
// peripheral side (slave).
//   io_rd / io_wr      : one-cycle read / write strobes
//   mem_addr           : IO address, valid with the strobes
//   dout               : CPU write data
//   io_din             : registered read data back to the CPU
//   interrupt_request  : level interrupt to the CPU
// ---------------------------------------------------------------------------
interface uart_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] io_din;
    logic        interrupt_request;

    modport master (
        output io_rd, io_wr, mem_addr, dout,
        input  io_din, interrupt_request
    );

    modport slave (
        input  io_rd, io_wr, mem_addr, dout,
        output io_din, interrupt_request
    );
endinterface

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Synchronous FIFO, DEPTH entries (power of 2) of WIDTH bits.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   i_push     : write i_din (ignored when full unless a pop succeeds too)
//   i_pop      : drop the head entry (ignored when empty)
//   o_dout     : head entry (valid when !o_empty)
//   o_empty    : no entries
//   o_full     : DEPTH entries
// A same-cycle push and pop is ordered pop-then-push, so a full FIFO
// accepts the push and an empty FIFO only takes the push.
// ---------------------------------------------------------------------------
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_dout    = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop_ok)  r_rp <= r_rp + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/uart_io.sv
// ---------------------------------------------------------------------------
// uart_io
// Memory-mapped 8N1 UART with TX and RX FIFOs.
//   clk, reset        : clock, synchronous active-high reset
//   io_rd, io_wr      : one-cycle CPU read / write strobes
//   mem_addr          : bit 12 selects DATA, bit 13 selects STATUS
//   dout              : CPU write data
//   io_din            : read data, registered on io_rd and held
//   interrupt_request : irq_en & rx_not_empty (registered)
//   uart_rx / uart_tx : serial in (asynchronous) / serial out (idle high)
// STATUS = {12'h000, irq_en, overrun, rx_not_empty, tx_not_full}.
// Build option: define UART_IRQ_EN to enable the interrupt; otherwise
// interrupt_request is 0 and irq_en reads 0.
// ---------------------------------------------------------------------------
module uart_io
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] io_din,
    output logic        interrupt_request,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic        w_sel_data, w_sel_status, w_irq_en;
    logic        w_tx_empty, w_tx_full, w_tx_pop, w_tx_tick, w_tx_bit;
    logic        w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_tick, w_rx_half;
    logic [7:0]  w_tx_dout, w_rx_dout;
    logic [15:0] w_status, w_rd_data;
    tx_state_t   r_tx_state, w_tx_next;
    rx_state_t   r_rx_state, w_rx_next;
    logic [CW-1:0] r_tx_cnt, r_rx_cnt;
    logic [2:0]  r_tx_idx, r_rx_idx;
    logic [7:0]  r_tx_shift, r_rx_shift;
    logic        r_tx, r_rx_s1, r_rx_s2, r_rx_prev, r_overrun;
    logic [15:0] r_io_din;

    assign w_sel_data   = mem_addr[ADDR_DATA_BIT];
    assign w_sel_status = mem_addr[ADDR_STATUS_BIT];

    uart_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .i_push(io_wr && w_sel_data), .i_din(dout[7:0]), .i_pop(w_tx_pop),
        .o_dout(w_tx_dout), .o_empty(w_tx_empty), .o_full(w_tx_full)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .i_push(w_rx_push), .i_din(r_rx_shift), .i_pop(w_rx_pop),
        .o_dout(w_rx_dout), .o_empty(w_rx_empty), .o_full(w_rx_full)
    );

    // ---------------- transmitter ----------------
    assign w_tx_tick = (r_tx_cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        w_tx_bit  = 1'b1;
        case (r_tx_state)
            TX_IDLE:  if (!w_tx_empty) begin w_tx_next = TX_START; w_tx_pop = 1'b1; end
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_idx == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) begin
                          if (!w_tx_empty) begin w_tx_next = TX_START; w_tx_pop = 1'b1; end
                          else w_tx_next = TX_IDLE;
                      end
            default:  w_tx_next = TX_IDLE;
        endcase
        // Line level is registered from the next state so uart_tx has no
        // combinational path; mid-DATA bit changes look one bit ahead.
        case (w_tx_next)
            TX_START: w_tx_bit = 1'b0;
            TX_DATA:  w_tx_bit = (r_tx_state == TX_DATA && w_tx_tick) ? r_tx_shift[1] : r_tx_shift[0];
            default:  w_tx_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx       <= w_tx_bit;
            if (r_tx_state == TX_IDLE || w_tx_tick) r_tx_cnt <= '0;
            else                                     r_tx_cnt <= r_tx_cnt + 1'b1;
            if (w_tx_pop) r_tx_shift <= w_tx_dout;
            else if (r_tx_state == TX_DATA && w_tx_tick) r_tx_shift <= r_tx_shift >> 1;
            if (r_tx_state == TX_DATA && w_tx_tick) r_tx_idx <= r_tx_idx + 1'b1;
        end
    end

    // ---------------- receiver ----------------
    assign w_rx_tick = (r_rx_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_rx_half = (r_rx_cnt == CW'(CLKS_PER_BIT / 2 - 1));

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_push = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_next = RX_START;
            RX_START: if (w_rx_half) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_idx == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) begin
                          w_rx_next = RX_IDLE;
                          w_rx_push = r_rx_s2;   // stop bit 0: framing error, discard
                      end
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_rx_tick) r_rx_cnt <= '0;
            else                                                                r_rx_cnt <= r_rx_cnt + 1'b1;
            if (w_rx_next == RX_START) r_rx_idx <= '0;
            else if (r_rx_state == RX_DATA && w_rx_tick) r_rx_idx <= r_rx_idx + 1'b1;
            if (r_rx_state == RX_DATA && w_rx_tick) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        end
    end

    // ---------------- CPU register interface ----------------
    always_comb begin
        w_status                  = '0;
        w_status[ST_TX_NOT_FULL]  = !w_tx_full;
        w_status[ST_RX_NOT_EMPTY] = !w_rx_empty;
        w_status[ST_OVERRUN]      = r_overrun;
        w_status[ST_IRQ_EN]       = w_irq_en;
    end

    assign w_rx_pop  = io_rd && w_sel_data && !w_rx_empty;
    assign w_rd_data = ((w_sel_data && !w_rx_empty) ? {8'h00, w_rx_dout} : 16'h0000)
                     | (w_sel_status ? w_status : 16'h0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_io_din  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (io_rd) r_io_din <= w_rd_data;
            // A byte only drops when the FIFO stays full through this cycle.
            if (w_rx_push && w_rx_full && !w_rx_pop)
                r_overrun <= 1'b1;
            else if (io_wr && w_sel_status && dout[ST_OVERRUN])
                r_overrun <= 1'b0;
        end
    end

    assign io_din  = r_io_din;
    assign uart_tx = r_tx;

`ifdef UART_IRQ_EN
    logic r_irq_en, r_irq;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (io_wr && w_sel_status) r_irq_en <= dout[ST_IRQ_EN];
            r_irq <= r_irq_en && !w_rx_empty;
        end
    end
    assign w_irq_en          = r_irq_en;
    assign interrupt_request = r_irq;
    logic w_unused_bits;
    assign w_unused_bits = ^{mem_addr[15:14], mem_addr[11:0], dout[15:8]};
`else
    assign w_irq_en          = 1'b0;
    assign interrupt_request = 1'b0;
    logic w_unused_bits;
    assign w_unused_bits = ^{mem_addr[15:14], mem_addr[11:0], dout[15:8], dout[3]};
`endif
endmodule

// File: tb/tb_uart_io.sv
module tb_uart_io;
    localparam int CPB = 4;
    localparam int DEP = 8;
    localparam logic [15:0] A_DATA   = 16'h1000;
    localparam logic [15:0] A_STATUS = 16'h2000;
    localparam logic [15:0] A_BOTH   = 16'h3000;

    logic clk = 1'b0;
    logic reset;
    logic uart_rx;
    logic uart_tx;
    int   n_vec = 0;
    int   n_err = 0;

    uart_if bus ();

    uart_io #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
        .clk(clk),
        .reset(reset),
        .io_rd(bus.io_rd),
        .io_wr(bus.io_wr),
        .mem_addr(bus.mem_addr),
        .dout(bus.dout),
        .io_din(bus.io_din),
        .interrupt_request(bus.interrupt_request),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] addr, input logic [15:0] data);
        bus.mem_addr = addr;
        bus.dout     = data;
        bus.io_wr    = 1'b1;
        tick();
        bus.io_wr    = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] addr);
        bus.mem_addr = addr;
        bus.io_rd    = 1'b1;
        tick();
        bus.io_rd    = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) tick();
        end
        uart_rx = stop_bit;
        repeat (CPB) tick();
        uart_rx = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        logic [7:0] tx_byte;
        logic       exp_bit;

        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
        bus.mem_addr = '0;
        bus.dout = '0;
        uart_rx = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_io_din", bus.io_din, 16'h0000);
        check("rst_irq", {15'b0, bus.interrupt_request}, 16'h0000);
        check("rst_tx", {15'b0, uart_tx}, 16'h0001);
        reset = 1'b0;
        tick();

        cpu_rd(A_STATUS);
        check("status_idle", bus.io_din, 16'h0001);
        tick();
        check("io_din_hold", bus.io_din, 16'h0001);
        cpu_rd(16'h0000);
        check("no_select_rd", bus.io_din, 16'h0000);
        cpu_rd(A_DATA);
        check("data_rd_empty", bus.io_din, 16'h0000);
        cpu_rd(A_BOTH);
        check("both_rd_empty", bus.io_din, 16'h0001);

        // TX frame of 0x55: start, 8 data bits LSB first, stop
        cpu_wr(A_DATA, 16'h0055);
        check("tx_still_idle", {15'b0, uart_tx}, 16'h0001);
        tick();
        tx_byte = 8'h55;
        for (int s = 0; s < 10; s++) begin
            if (s == 0)      exp_bit = 1'b0;
            else if (s == 9) exp_bit = 1'b1;
            else             exp_bit = tx_byte[s-1];
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("tx_sym%0d_c%0d", s, c), {15'b0, uart_tx}, {15'b0, exp_bit});
                tick();
            end
        end
        check("tx_back_idle", {15'b0, uart_tx}, 16'h0001);

        // RX of 0xA3
        send_rx(8'hA3, 1'b1);
        cpu_rd(A_STATUS);
        check("rx_status_full", bus.io_din, 16'h0003);
        cpu_rd(A_DATA);
        check("rx_data_a3", bus.io_din, 16'h00A3);
        cpu_rd(A_STATUS);
        check("rx_status_empty", bus.io_din, 16'h0001);

        // overrun: DEPTH+1 bytes with no reads
        for (int i = 0; i <= DEP; i++) send_rx(8'h30 + 8'(i), 1'b1);
        cpu_rd(A_STATUS);
        check("ovr_status", bus.io_din, 16'h0007);
        cpu_wr(A_STATUS, 16'h0004);
        cpu_rd(A_STATUS);
        check("ovr_cleared", bus.io_din, 16'h0003);
        for (int i = 0; i < DEP; i++) begin
            cpu_rd(A_DATA);
            check($sformatf("ovr_byte%0d", i), bus.io_din, {8'h00, 8'h30 + 8'(i)});
        end
        cpu_rd(A_DATA);
        check("ovr_dropped", bus.io_din, 16'h0000);
        cpu_rd(A_STATUS);
        check("ovr_final", bus.io_din, 16'h0001);

        // glitch and framing error
        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        repeat (12) tick();
        cpu_rd(A_STATUS);
        check("glitch_status", bus.io_din, 16'h0001);
        send_rx(8'h3C, 1'b0);
        cpu_rd(A_STATUS);
        check("frame_err_status", bus.io_din, 16'h0001);

        // interrupt
        cpu_wr(A_STATUS, 16'h0008);
        check("irq_no_data", {15'b0, bus.interrupt_request}, 16'h0000);
        send_rx(8'h5C, 1'b1);
`ifdef UART_IRQ_EN
        check("irq_raised", {15'b0, bus.interrupt_request}, 16'h0001);
        cpu_rd(A_STATUS);
        check("irq_status", bus.io_din, 16'h000B);
`else
        check("irq_tied_low", {15'b0, bus.interrupt_request}, 16'h0000);
        cpu_rd(A_STATUS);
        check("irq_en_reads0", bus.io_din, 16'h0003);
`endif
        cpu_rd(A_DATA);
        check("irq_data", bus.io_din, 16'h005C);
        tick();
        check("irq_lowered", {15'b0, bus.interrupt_request}, 16'h0000);
        cpu_wr(A_STATUS, 16'h0000);

        // TX FIFO fill: first byte is popped right away, so DEPTH+1 writes fill it
        for (int i = 0; i <= DEP; i++) cpu_wr(A_DATA, 16'h0000 + 16'(i));
        cpu_rd(A_STATUS);
        check("tx_full_status", bus.io_din, 16'h0000);
        cpu_wr(A_DATA, 16'h00EE);
        cpu_rd(A_STATUS);
        check("tx_still_full", bus.io_din, 16'h0000);

        // reset in the middle of the first frame (byte 0x00, line low)
        repeat (10) tick();
        check("tx_mid_frame_low", {15'b0, uart_tx}, 16'h0000);
        reset = 1'b1;
        tick();
        check("tx_after_reset", {15'b0, uart_tx}, 16'h0001);
        check("io_din_after_reset", bus.io_din, 16'h0000);
        reset = 1'b0;
        cpu_rd(A_STATUS);
        check("status_after_reset", bus.io_din, 16'h0001);
        repeat (2 * CPB) tick();
        check("tx_idle_after_reset", {15'b0, uart_tx}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
